conv_encoder_213: RTL

//  Framed rate-1/2, memory-3 (2,1,3) convolutional encoder with zero-tail termination.

---
 rtl/conv_encoder_213_pkg.sv | 26 ++
 rtl/conv_encoder_213_shift.sv | 42 ++++
 rtl/conv_encoder_213.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_encoder_213_pkg.sv
// ============================================================================
// Module      : conv_encoder_213_pkg
// Description : Constants shared by the (2,1,3) encoder, decoder and benches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_encoder_213_pkg;

  localparam int c_ENC_N = 2;
  localparam int c_ENC_K = 1;
  localparam int c_ENC_M = 3;

  localparam logic [3:0] c_ENC_G1 = 4'b1011;
  localparam logic [3:0] c_ENC_G2 = 4'b1111;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_IDLE = 2'd0;
  localparam state_t c_ST_DATA = 2'd1;
  localparam state_t c_ST_TAIL = 2'd2;
  localparam state_t c_ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/conv_encoder_213_shift.sv
// ============================================================================
// Module      : enc213_shift
// Description : Encoder memory register with the two generator parity taps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc213_shift
  import conv_encoder_213_pkg::*;
#(
  parameter int         M  = c_ENC_M,
  parameter logic [M:0] G1 = c_ENC_G1,
  parameter logic [M:0] G2 = c_ENC_G2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_shift,
  input  logic i_u,
  output logic o_c1,
  output logic o_c2
);

  // r_sr[M-1] holds u_{t-1}, r_sr[0] holds u_{t-M}
  logic [M-1:0] r_sr;
  logic [M:0]   w_taps;

  assign w_taps = {i_u, r_sr};
  assign o_c1   = ^(G1 & w_taps);
  assign o_c2   = ^(G2 & w_taps);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {i_u, r_sr[M-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_encoder_213.sv
// ============================================================================
// Module      : conv_encoder_213
// Description : Framed, paced (2,1,3) convolutional encoder with zero tail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder_213
  import conv_encoder_213_pkg::*;
#(
  parameter int         FRAME_LEN = 20,
  parameter int         HOLD      = 3,
  parameter int         M         = c_ENC_M,
  parameter logic [M:0] G1        = c_ENC_G1,
  parameter logic [M:0] G2        = c_ENC_G2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_din,
  input  logic       i_din_valid,
  output logic       o_din_ready,
  output logic [1:0] o_sym_out,
  output logic       o_sym_valid,
  output logic       o_seq_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int c_BIT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int c_HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int c_TAIL_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [c_BIT_W-1:0]  c_LAST_BIT    = c_BIT_W'(FRAME_LEN - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(HOLD - 1);
  localparam logic [c_TAIL_W-1:0] c_LAST_TAIL   = c_TAIL_W'(M - 1);

  state_t              r_state;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_TAIL_W-1:0] r_tail_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [1:0]          r_sym_out;
  logic                r_sym_valid;
  logic                r_seq_ready;
  logic                r_frame_done;

  logic w_hold_zero;
  logic w_din_ready;
  logic w_accept;
  logic w_tail_issue;
  logic w_issue;
  logic w_u;
  logic w_clr;
  logic w_c1;
  logic w_c2;

  assign w_hold_zero  = (r_hold_cnt == '0);
  assign w_din_ready  = (r_state == c_ST_DATA) && w_hold_zero;
  assign w_accept     = w_din_ready && i_din_valid;
  assign w_tail_issue = (r_state == c_ST_TAIL) && w_hold_zero;
  assign w_issue      = w_accept || w_tail_issue;
  // Tail symbols are driven by a forced zero so the trellis ends in state 0
  assign w_u          = (r_state == c_ST_DATA) ? i_din : 1'b0;
  assign w_clr        = (r_state == c_ST_IDLE) && i_start;

  enc213_shift #(
    .M  (M),
    .G1 (G1),
    .G2 (G2)
  ) u_shift (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_shift (w_issue),
    .i_u     (w_u),
    .o_c1    (w_c1),
    .o_c2    (w_c2)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= c_ST_IDLE;
      r_bit_cnt    <= '0;
      r_tail_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_sym_out    <= 2'b00;
      r_sym_valid  <= 1'b0;
      r_seq_ready  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sym_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_issue) begin
        r_sym_out   <= {w_c1, w_c2};
        r_sym_valid <= 1'b1;
        r_seq_ready <= 1'b1;
        r_hold_cnt  <= c_HOLD_RELOAD;
      end else if (!w_hold_zero) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (i_start) begin
            r_state    <= c_ST_DATA;
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
            r_hold_cnt <= '0;
          end
        end
        c_ST_DATA: begin
          if (w_accept) begin
            if (r_bit_cnt == c_LAST_BIT) begin
              r_state   <= c_ST_TAIL;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        c_ST_TAIL: begin
          if (w_tail_issue) begin
            if (r_tail_cnt == c_LAST_TAIL) begin
              r_state    <= c_ST_DONE;
              r_tail_cnt <= '0;
            end else begin
              r_tail_cnt <= r_tail_cnt + 1'b1;
            end
          end
        end
        c_ST_DONE: begin
          // Last tail symbol has had its full hold time on the line
          if (w_hold_zero) begin
            r_frame_done <= 1'b1;
            r_seq_ready  <= 1'b0;
            r_state      <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign o_din_ready  = w_din_ready;
  assign o_sym_out    = r_sym_out;
  assign o_sym_valid  = r_sym_valid;
  assign o_seq_ready  = r_seq_ready;
  assign o_busy       = (r_state != c_ST_IDLE);
  assign o_frame_done = r_frame_done;

endmodule

`default_nettype wire
